// File: rtl/pedagio_ctrl_if.sv
// rtl/pedagio_ctrl_if.sv - toll booth controller sensor, coin and display signal bundle
interface pedagio_ctrl_if;
    logic       vehicle_present;
    logic [1:0] cat;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       vehicle_passed;
    logic       gate_open;
    logic       E1;
    logic       E0;
    logic [3:0] P;
    logic       change_valid;
    logic [3:0] change;
    logic       refund_valid;
    logic [3:0] refund;
    logic       coin_reject;
    logic       busy;

    modport master (
        output vehicle_present, cat, coin_valid, coin_value, vehicle_passed,
        input  gate_open, E1, E0, P, change_valid, change, refund_valid, refund,
               coin_reject, busy
    );

    modport slave (
        input  vehicle_present, cat, coin_valid, coin_value, vehicle_passed,
        output gate_open, E1, E0, P, change_valid, change, refund_valid, refund,
               coin_reject, busy
    );
endinterface

// File: rtl/pedagio_ctrl.sv
// rtl/pedagio_ctrl.sv - toll booth controller: category latch, coin collection, gate, change and refund
module pedagio_ctrl #(
    parameter logic [3:0] FARE0   = 4'd3,
    parameter logic [3:0] FARE1   = 4'd5,
    parameter logic [3:0] FARE2   = 4'd8,
    parameter logic [3:0] FARE3   = 4'd12,
    parameter int         TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    pedagio_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHARGE = 2'd1;
    localparam logic [1:0] S_OPEN   = 2'd2;
    localparam logic [1:0] S_REFUND = 2'd3;

    logic [1:0]    state;
    logic [3:0]    due;
    logic [4:0]    paid;
    logic [TW-1:0] timer;

    logic       gate_open_r, change_valid_r, refund_valid_r, coin_reject_r, busy_r;
    logic [1:0] cat_r;
    logic [3:0] p_r, change_r, refund_r;

    logic [3:0] fare_sel;
    logic [4:0] sum;
    logic       coin_ok;

    always_comb begin
        fare_sel = FARE0;
        case (bus.cat)
            2'd0:    fare_sel = FARE0;
            2'd1:    fare_sel = FARE1;
            2'd2:    fare_sel = FARE2;
            default: fare_sel = FARE3;
        endcase
    end

    // Zero-value strobes are ignored everywhere: never accepted, never rejected.
    assign coin_ok = bus.coin_valid && (bus.coin_value != 4'd0);
    assign sum     = paid + {1'b0, bus.coin_value};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            due            <= 4'd0;
            paid           <= 5'd0;
            timer          <= '0;
            gate_open_r    <= 1'b0;
            cat_r          <= 2'd0;
            p_r            <= 4'd0;
            change_valid_r <= 1'b0;
            change_r       <= 4'd0;
            refund_valid_r <= 1'b0;
            refund_r       <= 4'd0;
            coin_reject_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            change_valid_r <= 1'b0;
            refund_valid_r <= 1'b0;
            coin_reject_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    coin_reject_r <= coin_ok;
                    if (bus.vehicle_present) begin
                        cat_r  <= bus.cat;
                        due    <= fare_sel;
                        paid   <= 5'd0;
                        timer  <= '0;
                        busy_r <= 1'b1;
                        if (fare_sel != 4'd0) begin
                            state <= S_CHARGE;
                            p_r   <= fare_sel;
                        end else begin
                            state          <= S_OPEN;
                            gate_open_r    <= 1'b1;
                            change_r       <= 4'd0;
                            change_valid_r <= 1'b1;
                            p_r            <= 4'd0;
                        end
                    end
                end
                S_CHARGE: begin
                    // An accepted coin outranks both abandonment and timeout in the same cycle.
                    if (coin_ok) begin
                        if (sum >= {1'b0, due}) begin
                            state          <= S_OPEN;
                            gate_open_r    <= 1'b1;
                            change_r       <= 4'(sum - {1'b0, due});
                            change_valid_r <= 1'b1;
                            p_r            <= 4'd0;
                        end else begin
                            paid  <= sum;
                            p_r   <= due - sum[3:0];
                            timer <= '0;
                            if (!bus.vehicle_present) begin
                                state          <= S_REFUND;
                                refund_r       <= sum[3:0];
                                refund_valid_r <= 1'b1;
                            end
                        end
                    end else if (!bus.vehicle_present || timer == TLAST) begin
                        state <= S_REFUND;
                        if (paid != 5'd0) begin
                            refund_r       <= paid[3:0];
                            refund_valid_r <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OPEN: begin
                    coin_reject_r <= coin_ok;
                    if (bus.vehicle_passed) begin
                        state       <= S_IDLE;
                        gate_open_r <= 1'b0;
                        p_r         <= 4'd0;
                        cat_r       <= 2'd0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    coin_reject_r <= coin_ok;
                    state         <= S_IDLE;
                    p_r           <= 4'd0;
                    cat_r         <= 2'd0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate_open    = gate_open_r;
    assign bus.E1           = cat_r[1];
    assign bus.E0           = cat_r[0];
    assign bus.P            = p_r;
    assign bus.change_valid = change_valid_r;
    assign bus.change       = change_r;
    assign bus.refund_valid = refund_valid_r;
    assign bus.refund       = refund_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_pedagio_ctrl.sv
// tb/tb_pedagio_ctrl.sv - table-driven and scoreboard checks for the toll booth controller
module tb_pedagio_ctrl;
    localparam int TIMEOUT = 16;
    localparam int NVEC    = 29;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pedagio_ctrl_if bus();

    pedagio_ctrl #(
        .FARE0(4'd3), .FARE1(4'd5), .FARE2(4'd8), .FARE3(4'd12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic       rst;
        logic       vp;
        logic [1:0] cat;
        logic       cv;
        logic [3:0] cval;
        logic       pas;
    } in_t;

    typedef struct packed {
        logic       g;
        logic [1:0] e;
        logic [3:0] p;
        logic       chv;
        logic [3:0] chg;
        logic       rfv;
        logic [3:0] rf;
        logic       rej;
        logic       busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct {
        out_t o;
        int   tag;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic in_t mk_in(input logic r, input logic vp, input logic [1:0] c,
                                  input logic cv, input logic [3:0] cval, input logic pas);
        in_t x;
        x.rst = r; x.vp = vp; x.cat = c; x.cv = cv; x.cval = cval; x.pas = pas;
        return x;
    endfunction

    function automatic out_t mk_out(input logic g, input logic [1:0] e, input logic [3:0] p,
                                    input logic chv, input logic [3:0] chg, input logic rfv,
                                    input logic [3:0] rf, input logic rej, input logic busy);
        out_t x;
        x.g = g; x.e = e; x.p = p; x.chv = chv; x.chg = chg;
        x.rfv = rfv; x.rf = rf; x.rej = rej; x.busy = busy;
        return x;
    endfunction

    function automatic vec_t v(input logic r, input logic vp, input logic [1:0] c, input logic cv,
                               input logic [3:0] cval, input logic pas, input logic g,
                               input logic [1:0] e, input logic [3:0] p, input logic chv,
                               input logic [3:0] chg, input logic rfv, input logic [3:0] rf,
                               input logic rej, input logic busy);
        vec_t x;
        x.i = mk_in(r, vp, c, cv, cval, pas);
        x.o = mk_out(g, e, p, chv, chg, rfv, rf, rej, busy);
        return x;
    endfunction

    function automatic string fmt(input out_t x);
        return $sformatf("gate=%b E=%0d P=%0d chv=%b change=%0d rfv=%b refund=%0d rej=%b busy=%b",
                         x.g, x.e, x.p, x.chv, x.chg, x.rfv, x.rf, x.rej, x.busy);
    endfunction

    task automatic check_out();
        sb_t  ex;
        out_t act;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got empty queue, required one pending expectation");
        end else begin
            ex = sb.pop_front();
            act = mk_out(bus.gate_open, {bus.E1, bus.E0}, bus.P, bus.change_valid, bus.change,
                         bus.refund_valid, bus.refund, bus.coin_reject, bus.busy);
            if (act !== ex.o) begin
                n_fail++;
                $display("FAIL step%0d: got %s required %s", ex.tag, fmt(act), fmt(ex.o));
            end
        end
    endtask

    task automatic drive(input in_t i, input out_t o, input int tag);
        sb_t s;
        @(negedge clk);
        rst_n               = i.rst;
        bus.vehicle_present = i.vp;
        bus.cat             = i.cat;
        bus.coin_valid      = i.cv;
        bus.coin_value      = i.cval;
        bus.vehicle_passed  = i.pas;
        s.o = o;
        s.tag = tag;
        sb.push_back(s);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.vehicle_present = 1'b0;
        bus.cat             = 2'd0;
        bus.coin_valid      = 1'b0;
        bus.coin_value      = 4'd0;
        bus.vehicle_passed  = 1'b0;

        //          r vp c cv cv  ps  g e  p chv chg rfv rf rej busy
        tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = v(1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1);
        tbl[3]  = v(1, 1, 1, 1, 2, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1);
        tbl[4]  = v(1, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1);
        tbl[5]  = v(1, 1, 1, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[6]  = v(1, 1, 1, 1, 4, 0, 1, 1, 0, 1, 3, 0, 0, 0, 1);
        tbl[7]  = v(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 3, 0, 0, 0, 1);
        tbl[8]  = v(1, 1, 1, 1, 3, 0, 1, 1, 0, 0, 3, 0, 0, 1, 1);
        tbl[9]  = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[10] = v(1, 1, 3, 0, 0, 0, 0, 3, 12, 0, 3, 0, 0, 0, 1);
        tbl[11] = v(1, 1, 3, 1, 15, 0, 1, 3, 0, 1, 3, 0, 0, 0, 1);
        tbl[12] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[13] = v(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0);
        tbl[14] = v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[15] = v(1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 1);
        tbl[16] = v(1, 0, 0, 1, 1, 0, 0, 0, 2, 0, 3, 1, 1, 0, 1);
        tbl[17] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
        tbl[18] = v(1, 1, 2, 0, 0, 0, 0, 2, 8, 0, 3, 0, 1, 0, 1);
        tbl[19] = v(1, 0, 2, 0, 0, 0, 0, 2, 8, 0, 3, 0, 1, 0, 1);
        tbl[20] = v(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0);
        tbl[21] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
        tbl[22] = v(1, 1, 2, 0, 0, 0, 0, 2, 8, 0, 3, 0, 1, 0, 1);
        tbl[23] = v(1, 1, 0, 1, 15, 0, 1, 2, 0, 1, 7, 0, 1, 0, 1);
        tbl[24] = v(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 7, 0, 1, 0, 0);
        tbl[25] = v(1, 1, 1, 0, 0, 0, 0, 1, 5, 0, 7, 0, 1, 0, 1);
        tbl[26] = v(1, 1, 1, 1, 4, 0, 0, 1, 1, 0, 7, 0, 1, 0, 1);
        tbl[27] = v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[28] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < NVEC; k++) drive(tbl[k].i, tbl[k].o, k);

        // Timeout with coin 5 paid on category 10
        drive(mk_in(1, 1, 2, 0, 0, 0), mk_out(0, 2, 8, 0, 0, 0, 0, 0, 1), 100);
        drive(mk_in(1, 1, 2, 1, 5, 0), mk_out(0, 2, 3, 0, 0, 0, 0, 0, 1), 101);
        for (int k = 0; k < TIMEOUT - 1; k++)
            drive(mk_in(1, 1, 2, 0, 0, 0), mk_out(0, 2, 3, 0, 0, 0, 0, 0, 1), 102);
        drive(mk_in(1, 1, 2, 0, 0, 0), mk_out(0, 2, 3, 0, 0, 1, 5, 0, 1), 103);
        drive(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 5, 0, 0), 104);

        // Non-paying coin on the timeout cycle restarts the timer
        drive(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 3, 0, 0, 0, 5, 0, 1), 200);
        drive(mk_in(1, 1, 0, 1, 1, 0), mk_out(0, 0, 2, 0, 0, 0, 5, 0, 1), 201);
        for (int k = 0; k < TIMEOUT - 1; k++)
            drive(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 2, 0, 0, 0, 5, 0, 1), 202);
        drive(mk_in(1, 1, 0, 1, 1, 0), mk_out(0, 0, 1, 0, 0, 0, 5, 0, 1), 203);
        for (int k = 0; k < TIMEOUT - 1; k++)
            drive(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 5, 0, 1), 204);
        drive(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 1, 2, 0, 1), 205);
        drive(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 2, 0, 0), 206);

        // Paying coin on the timeout cycle opens the gate
        drive(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 3, 0, 0, 0, 2, 0, 1), 300);
        drive(mk_in(1, 1, 0, 1, 1, 0), mk_out(0, 0, 2, 0, 0, 0, 2, 0, 1), 301);
        for (int k = 0; k < TIMEOUT - 1; k++)
            drive(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 2, 0, 0, 0, 2, 0, 1), 302);
        drive(mk_in(1, 1, 0, 1, 3, 0), mk_out(1, 0, 0, 1, 1, 0, 2, 0, 1), 303);
        drive(mk_in(1, 0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 1, 0, 2, 0, 0), 304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pedagio_ctrl.md
# pedagio_ctrl

Sequential controller for the toll booth. It detects an arriving vehicle, latches its category, and collects coins until the fare is covered. It then opens the gate and reports change, or refunds on timeout or abandonment. Its E1/E0/P outputs drive the existing pedagio seven-segment display decoder, so the display always shows the latched category and the amount still due.

## Interface
- FARE0, 4'd3: fare for category 00
- FARE1, 4'd5: fare for category 01
- FARE2, 4'd8: fare for category 10
- FARE3, 4'd12: fare for category 11
- TIMEOUT, 16: idle cycles in CHARGE before refund; must be ≥2
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- vehicle_present  input  1  presence sensor, level
- cat  input  2  vehicle category; sampled only on IDLE→CHARGE
- coin_valid  input  1  one-cycle coin strobe
- coin_value  input  4  coin value, 1..15; 0 is ignored and not rejected
- vehicle_passed  input  1  exit sensor strobe
- gate_open  output  1  gate actuator
- E1, E0  output  1 each  latched category to the display decoder
- P  output  4  amount still due, to the display decoder
- change_valid  output  1  one-cycle pulse
- change  output  4  change amount, held until the next change_valid
- refund_valid  output  1  one-cycle pulse
- refund  output  4  refund amount, held until the next refund_valid
- coin_reject  output  1  one-cycle pulse, coin returned unaccepted
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, CHARGE, OPEN, REFUND. Encoding is free; all outputs are registered.
- Internal registers: due (4b), paid (5b), timer (counts up to TIMEOUT).
- IDLE, vehicle_present=1: latch cat into E1/E0, load due with FARE[cat], clear paid and timer.
  - Fare nonzero: go to CHARGE, P=fare.
  - Fare zero: go straight to OPEN with change=0 and a change_valid pulse.
- CHARGE, priority order per cycle:
  1. coin_valid with coin_value≠0: sum=paid+coin_value (5b, maximum 29, no overflow).
     - sum≥due: go to OPEN, change=sum−due (always <16), change_valid=1, P=0.
     - Otherwise: paid=sum, P=due−sum, timer cleared.
  2. vehicle_present=0: go to REFUND.
  3. timer==TIMEOUT−1: go to REFUND.
  4. Otherwise: timer+1.
- A coin arriving in the same cycle as the timeout or as vehicle_present falling is accepted first.
  - If the coin completes payment, the controller goes to OPEN.
  - If it does not, vehicle_present=0 sends the controller to REFUND with the coin included in paid. A timeout is cancelled, because the coin clears the timer.
- OPEN: gate_open=1. On vehicle_passed, go to IDLE with gate_open=0, P=0, E1/E0=0.
- REFUND: entered with refund=paid.
  - If paid≠0, refund_valid pulses on the entry cycle.
  - Return to IDLE next cycle, clearing P and E1/E0.
- A coin_valid in IDLE, OPEN or REFUND is not accepted and pulses coin_reject on the next cycle.
- IDLE with vehicle_present still high immediately after OPEN or REFUND starts a new transaction; sensor debouncing is upstream.

## Timing
- Reset values: state=IDLE; gate_open, E1, E0, change_valid, refund_valid, coin_reject, busy all 0; P, change, refund all 0. Reset mid-transaction discards paid with no refund pulse.
- vehicle_present seen high at edge N: busy=1, E1/E0 and P valid after edge N.
- Paying coin sampled at edge N: gate_open=1 and change_valid=1 after edge N; change_valid drops after N+1.
- vehicle_passed sampled at edge M in OPEN: gate_open=0 after M.
- Timeout: with no coin, REFUND is entered TIMEOUT cycles after entering CHARGE or after the last coin. refund_valid is high for that cycle, then IDLE.
- Only one of change_valid and refund_valid is ever high in a given cycle.

## Test plan
- cat=01 (fare 5); coins 2, 2, 4 on separate cycles → P goes 5→3→1→0; gate_open rises the cycle after the 4-coin; change=3, change_valid for one cycle; vehicle_passed → IDLE, gate_open=0.
- cat=11 (fare 12); single coin 15 → OPEN; change=3.
- cat=10; coin 5, then no coins → TIMEOUT cycles later refund_valid=1 with refund=5; P=0, busy=0 on the next cycle.
- cat=00; coin 1 in the same cycle vehicle_present falls → REFUND with refund=1. Separately, vehicle_present drops with paid=0 → no refund_valid, back to IDLE.
- Coin in IDLE and in OPEN → coin_reject pulses, paid unchanged. rst_n low while in CHARGE with paid=4 → all outputs 0, no refund.
- Coin arriving exactly on the timeout cycle that completes the fare → OPEN, not REFUND.
